// File: rtl/memory_responder.sv
// Register-backed MemoryBus responder: a DEPTH-word window at BASE_ADDRESS,
// in-order read responses through a small FIFO, saturating error counter.
module memory_responder #(
  parameter int unsigned                DATA_WIDTH      = 24,
  parameter int unsigned                ADDRESS_WIDTH   = 32,
  parameter int unsigned                MASTER_ID_WIDTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS    = 'h1000000,
  parameter int unsigned                DEPTH           = 16,
  parameter int unsigned                FIFO_DEPTH      = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          reqValid,
  output logic                          reqReady,
  input  logic                          reqWrite,
  input  logic [ADDRESS_WIDTH-1:0]      reqAddress,
  input  logic [DATA_WIDTH-1:0]         reqData,
  input  logic [MASTER_ID_WIDTH-1:0]    reqMasterId,
  output logic                          respValid,
  input  logic                          respReady,
  output logic [DATA_WIDTH-1:0]         respData,
  output logic [MASTER_ID_WIDTH-1:0]    respMasterId,
  output logic                          respError,
  output logic [DEPTH*DATA_WIDTH-1:0]   registers,
  output logic [7:0]                    errorCount
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][DATA_WIDTH-1:0]           r_regs;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0]      r_fifo_data;
  logic [FIFO_DEPTH-1:0][MASTER_ID_WIDTH-1:0] r_fifo_id;
  logic [FIFO_DEPTH-1:0]                      r_fifo_err;
  logic [PTR_W-1:0]                           r_wr_ptr;
  logic [PTR_W-1:0]                           r_rd_ptr;
  logic [CNT_W-1:0]                           r_count;
  logic                                       r_req_ready;
  logic [7:0]                                 r_error_count;

  logic [ADDRESS_WIDTH-1:0] w_offset;
  logic [IDX_W-1:0]         w_index;
  logic                     w_in_window;
  logic                     w_accept;
  logic                     w_write;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_not_empty;
  logic [DATA_WIDTH-1:0]    w_read_data;
  logic [CNT_W-1:0]         w_count_next;

  // The lower-bound test stops addresses below the base from wrapping into the window.
  always_comb begin
    w_offset     = reqAddress - BASE_ADDRESS;
    w_index      = w_offset[IDX_W-1:0];
    w_in_window  = (reqAddress >= BASE_ADDRESS) && (w_offset < ADDRESS_WIDTH'(DEPTH));
    w_accept     = reqValid && r_req_ready;
    w_write      = w_accept && reqWrite;
    w_push       = w_accept && !reqWrite;
    w_not_empty  = (r_count != '0);
    w_pop        = w_not_empty && respReady;
    w_read_data  = w_in_window ? r_regs[w_index] : '0;
    w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_regs <= '0;
    end else if (w_write && w_in_window) begin
      r_regs[w_index] <= reqData;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fifo_data <= '0;
      r_fifo_id   <= '0;
      r_fifo_err  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_read_data;
        r_fifo_id[r_wr_ptr]   <= reqMasterId;
        r_fifo_err[r_wr_ptr]  <= !w_in_window;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count     <= w_count_next;
      r_req_ready <= (w_count_next < CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_error_count <= '0;
    end else if (w_accept && !w_in_window && (r_error_count != '1)) begin
      r_error_count <= r_error_count + 8'd1;
    end
  end

  // Response fields read zero whenever the FIFO is empty, not just out of reset.
  always_comb begin
    reqReady     = r_req_ready;
    respValid    = w_not_empty;
    respData     = w_not_empty ? r_fifo_data[r_rd_ptr] : '0;
    respMasterId = w_not_empty ? r_fifo_id[r_rd_ptr]   : '0;
    respError    = w_not_empty ? r_fifo_err[r_rd_ptr]  : 1'b0;
    registers    = r_regs;
    errorCount   = r_error_count;
  end

endmodule

// File: doc/memory_responder.md
# memory_responder

Register-backed slave for the `MemoryBus` request/response protocol. It is the responder end of the link that the ray tracer's bus masters and the config bridge drive. It decodes a window of `DEPTH` words at `BASE_ADDRESS`, and applies writes to an internal register array that is exported to the design. Reads are answered in order through a small response FIFO, so back-to-back reads are accepted while the master stalls the response channel.

## Interface
Parameters:
- `DATA_WIDTH`, 24: data word width.
- `ADDRESS_WIDTH`, 32: word address width.
- `MASTER_ID_WIDTH`, 8: requester ID width, echoed on responses.
- `BASE_ADDRESS`, 'h1000000: first word address of the window.
- `DEPTH`, 16: register count; power of two, at least 2.
- `FIFO_DEPTH`, 2: response FIFO entries; power of two, at least 2.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  responder accepts the request this cycle.
- `reqWrite`  in  1  1 = write, 0 = read.
- `reqAddress`  in  `ADDRESS_WIDTH`  word address.
- `reqData`  in  `DATA_WIDTH`  write data.
- `reqMasterId`  in  `MASTER_ID_WIDTH`  requester ID.
- `respValid`  out  1  read response present.
- `respReady`  in  1  master consumes the response.
- `respData`  out  `DATA_WIDTH`  read data.
- `respMasterId`  out  `MASTER_ID_WIDTH`  ID of the read that produced this response.
- `respError`  out  1  read address was outside the window.
- `registers`  out  `DEPTH*DATA_WIDTH`  register array; word i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `errorCount`  out  8  saturating count of out-of-window accesses.

## Operation
- **Handshake.**
  - A request transfers on an edge where `reqValid && reqReady`.
  - A response transfers on an edge where `respValid && respReady`.
  - While `reqValid && !reqReady`, the master holds all `req*` signals stable.
- **Decode.**
  - offset = `reqAddress - BASE_ADDRESS`, computed at `ADDRESS_WIDTH` bits.
  - The access is in the window when `reqAddress >= BASE_ADDRESS` and offset < `DEPTH`. Only offset[log2(DEPTH)-1:0] indexes the array.
  - `BASE_ADDRESS + DEPTH` is the first address outside the window; the window does not wrap.
- **Write, in window.** `registers[offset]` ← `reqData`. No response is generated.
- **Write, out of window.** Data is dropped, `errorCount` increments, and no response is generated.
- **Read.** The responder pushes {data, `reqMasterId`, error} into the response FIFO.
  - In window: data = `registers[offset]` as it stands before the edge, error = 0.
  - Out of window: data = 0, error = 1, and `errorCount` increments.
- **Response FIFO.**
  - FIFO order is strictly preserved.
  - `respValid` = FIFO not empty; the head entry drives `respData`, `respMasterId` and `respError`.
  - The count updates by +push −pop.
  - A push and a pop on the same edge leave the count unchanged; this is legal at any count below `FIFO_DEPTH`.
- **reqReady.** This is a register, set every edge to (next count < `FIFO_DEPTH`). Writes are gated by `reqReady` as well, to keep a single request rule.
- **errorCount.** Saturates at 255 and never wraps.

## Timing
- **Reset** (asynchronous assert, synchronous release):
  - `registers` = 0, FIFO empty, `respValid` = 0.
  - `respData`, `respMasterId`, `respError` = 0.
  - `errorCount` = 0, `reqReady` = 0.
  - `reqReady` rises on the first edge after release.
- **Reset mid-operation.** All FIFO contents and register values are discarded with no partial responses. A request presented during reset is not accepted.
- **Read latency.** A read accepted on edge N gives `respValid` = 1 in the cycle after edge N, when the FIFO was empty before N.
- **Throughput.** With `respReady` held high, one read per cycle is sustained indefinitely.
- **Write visibility.** A write on edge N is visible on `registers` after edge N, and to a read accepted on edge N+1.
- **Back-pressure.** With `respReady` = 0, the responder accepts `FIFO_DEPTH` reads, then `reqReady` = 0 from the following cycle.
  - A pop on edge M makes `reqReady` = 1 after edge M.
  - There is no combinational path from `respReady` to `reqReady`.

## Test plan
- **Reset values.** Check every output after reset release, including `reqReady` = 0 until the first edge, then 1.
- **Write then read.** Write 'hABCDEF to 'h1000003, then read 'h1000003 with ID 7 on the next cycle. Required: `respData` = 'hABCDEF, `respMasterId` = 7, `respError` = 0, and `registers` word 3 = 'hABCDEF.
- **Out-of-window accesses.** Read 'h1000010 and read 'hFFFFFF: each returns data 0 with `respError` = 1. A write to 'h2000000 leaves `registers` unchanged. `errorCount` = 3.
- **Back-pressure.** Hold `respReady` = 0 and issue reads with IDs 1, 2, 3 back-to-back.
  - IDs 1 and 2 are accepted; `reqReady` = 0 and ID 3 stalls.
  - Raise `respReady`: responses come out in ID order 1, 2, 3, with no loss or duplication.
- **Streaming and saturation.**
  - Issue 16 consecutive reads with `respReady` = 1: one response per cycle, one-cycle latency.
  - Issue 300 out-of-window writes: `errorCount` holds at 255.
- **Mid-operation reset.** Assert `reset` with 2 responses queued and `registers` non-zero. `respValid` drops immediately, `registers` = 0, and no stale response appears after release.
